nibble_fetch_decode: RTL and testbench
======================================

Name: nibble_fetch_decode

Overview:
- Upstream control stage for the 4-bit accumulator datapath (Procesamiento).
- Fetches 8-bit instructions from an external synchronous program ROM, decodes them, and drives the datapath controls: data_in, control, load_acu, enable_out_alu.
- Consumes the datapath C/Z flags for conditional jumps.
- Multi-cycle, non-pipelined sequencer with program counter, instruction register and flag registers.

Parameters:
- ADDR_W, 4, program counter / ROM address width; jump targets are the operand zero-extended to ADDR_W.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; state clears on the clk edge where reset==0.
- run  input  1  start request; sampled in IDLE.
- rom_addr  output  ADDR_W  program ROM address (= PC register).
- rom_data  input  8  ROM word, valid one cycle after rom_addr; {opcode[7:4], operand[3:0]}.
- c_in  input  1  datapath carry flag.
- z_in  input  1  datapath zero flag.
- data_in  output  4  operand to datapath dataIn.
- control  output  3  ALU operation to datapath control.
- load_acu  output  1  accumulator load strobe, one-cycle pulse.
- enable_out_alu  output  1  datapath output enable, level.
- halted  output  1  high in HALT state.

Behaviour:
- Reset: state=IDLE, pc=PC_RESET, ir=0, data_in=0, control=0, load_acu=0, enable_out_alu=0, halted=0, c_flag=z_flag=0.
- Reset mid-instruction aborts it. A load_acu pulse in progress drops at the reset edge.
- States: IDLE, FETCH, DECODE, EXECUTE, FLAGS, HALT.
- IDLE: waits for run==1, then goes to FETCH. run is ignored in every other state.
- FETCH: rom_addr=pc, one cycle → DECODE.
- DECODE: ir<=rom_data; data_in<=rom_data[3:0]; control<=rom_data[6:4] for ALU ops, otherwise held; pc<=pc+1 mod 2^ADDR_W → EXECUTE.
- EXECUTE, by opcode:
  - 0x0 NOP: no action.
  - 0x1–0x7 ALU: load_acu=1 this cycle only, control=opcode[2:0] → FLAGS.
  - 0x8 OUT: enable_out_alu<=operand[0].
  - 0x9 JMP: pc<=operand.
  - 0xA JC: jump if c_flag.
  - 0xB JZ: jump if z_flag.
  - 0xC JNC: jump if !c_flag.
  - 0xD JNZ: jump if !z_flag.
  - 0xE: reserved, treated as NOP.
  - 0xF HALT: → HALT.
  - Non-ALU, non-HALT opcodes → FETCH.
- FLAGS: c_flag<=c_in, z_flag<=z_in (accumulator updated at the EXECUTE edge) → FETCH.
- HALT: sticky until reset; halted=1; all outputs hold.
- Latency:
  - ALU op: 4 cycles.
  - Other ops: 3 cycles.
  - First FETCH one cycle after run sampled.
- Timing: data_in and control are stable from DECODE+1 through the end of the instruction, so they are valid throughout the load_acu cycle.
- A taken jump overrides the DECODE increment.
- Jump to the current address is legal and loops.
- PC wraps from 2^ADDR_W−1 to 0 without error.
- Flags change only in FLAGS state; jumps use the registered flags, never c_in/z_in directly.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input port step (1 bit).
  - FETCH is entered only on a cycle where step==1; otherwise the sequencer waits in a stall between instructions, with all outputs held.
  - Wait points are after reset/IDLE start and after each instruction completes.
- SINGLE_STEP_EN undefined: no step port; free-running as above.

Decomposition:
- Package nibble_pkg:
  - Opcode constants OP_NOP…OP_HALT.
  - State enum / localparams.
  - INSTR_W=8, OPND_W=4, CTRL_W=3.
- Sub-module nibble_decoder, combinational: opcode plus flags → is_alu, is_out, is_jump, jump_taken, is_halt.
- Sequencer FSM, PC, IR and flag registers live in nibble_fetch_decode.

Test Plan:
- Reset and idle:
  - reset=0 for 2 cycles, run=0 → all outputs 0, rom_addr=0, stays IDLE for 10 cycles.
  - run=1 → FETCH on the next cycle.
- ALU op:
  - ROM[0]=0x3F → in EXECUTE: data_in=4'hF, control=3'd3, load_acu high exactly 1 cycle.
  - Flags latched from c_in=1, z_in=0.
  - rom_addr=1 four cycles after the first FETCH.
- OUT/HALT:
  - ROM: 0x81, 0x80, 0xF0 → enable_out_alu 1 then 0; halted=1, and rom_addr stays 3 for 20 cycles.
  - run toggling has no effect while halted.
- Conditional jumps:
  - ROM[0]=0x10 with z_in=1 during FLAGS, ROM[1]=0xB5 → JZ taken, next fetch addr=5.
  - Repeat with z_in=0 → next fetch addr=2.
  - Repeat with JNZ → opposite outcomes.
- Wrap and mid-op reset:
  - JMP 0xF, ROM[15]=0x00 → next fetch addr=0.
  - Assert reset during an ALU EXECUTE cycle → load_acu=0, pc=0, state IDLE after that edge.
- SINGLE_STEP_EN:
  - Stream of NOPs, step pulsed every 8 cycles → exactly one instruction per step pulse.
  - rom_addr increments once per pulse.

Source files
------------

// File: rtl/nibble_pkg.sv
// nibble_pkg: shared constants and types for the nibble fetch/decode sequencer.
//   - instruction layout widths (INSTR_W, OPND_W, CTRL_W, OPC_W)
//   - opcode constants OP_NOP .. OP_HALT
//   - sequencer state encoding
//   - f_is_alu(): opcode classification shared by the decoder and the DECODE stage
package nibble_pkg;

  localparam int INSTR_W = 8;
  localparam int OPND_W  = 4;
  localparam int CTRL_W  = 3;
  localparam int OPC_W   = INSTR_W - OPND_W;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_ALU_LO = 4'h1;
  localparam logic [OPC_W-1:0] OP_ALU_HI = 4'h7;
  localparam logic [OPC_W-1:0] OP_OUT    = 4'h8;
  localparam logic [OPC_W-1:0] OP_JMP    = 4'h9;
  localparam logic [OPC_W-1:0] OP_JC     = 4'hA;
  localparam logic [OPC_W-1:0] OP_JZ     = 4'hB;
  localparam logic [OPC_W-1:0] OP_JNC    = 4'hC;
  localparam logic [OPC_W-1:0] OP_JNZ    = 4'hD;
  localparam logic [OPC_W-1:0] OP_RSVD   = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

  // ST_STEP is only reachable when single stepping is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_FLAGS   = 3'd4,
    ST_HALT    = 3'd5,
    ST_STEP    = 3'd6
  } state_e;

  // ALU opcodes are 0x1..0x7: top bit clear and not NOP.
  function automatic logic f_is_alu(input logic [OPC_W-1:0] opc);
    return (opc >= OP_ALU_LO) && (opc <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/nibble_fetch_decode_if.sv
// nibble_fetch_decode_if: program ROM port plus accumulator-datapath control bus.
//   master (sequencer): drives rom_addr, data_in, control, load_acu,
//                       enable_out_alu, halted; receives rom_data, c_in, z_in.
//   slave  (ROM + datapath side): the mirror image.
interface nibble_fetch_decode_if #(
  parameter int ADDR_W = 4
);
  import nibble_pkg::*;

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               c_in;
  logic               z_in;
  logic [OPND_W-1:0]  data_in;
  logic [CTRL_W-1:0]  control;
  logic               load_acu;
  logic               enable_out_alu;
  logic               halted;

  modport master (
    output rom_addr, data_in, control, load_acu, enable_out_alu, halted,
    input  rom_data, c_in, z_in
  );

  modport slave (
    input  rom_addr, data_in, control, load_acu, enable_out_alu, halted,
    output rom_data, c_in, z_in
  );

endinterface

// File: rtl/nibble_fetch_decode_decoder.sv
// nibble_decoder: purely combinational opcode classifier.
//   i_opcode     : instruction opcode (ir[7:4])
//   i_c_flag     : registered carry flag
//   i_z_flag     : registered zero flag
//   o_is_alu     : opcode 0x1..0x7
//   o_is_out     : OUT
//   o_is_jump    : any jump opcode (JMP/JC/JZ/JNC/JNZ)
//   o_jump_taken : jump condition satisfied (always for JMP)
//   o_is_halt    : HALT
module nibble_decoder
  import nibble_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_c_flag,
  input  logic             i_z_flag,
  output logic             o_is_alu,
  output logic             o_is_out,
  output logic             o_is_jump,
  output logic             o_jump_taken,
  output logic             o_is_halt
);

  // Opcode classification and jump-condition evaluation.
  always_comb begin
    o_is_alu     = f_is_alu(i_opcode);
    o_is_out     = 1'b0;
    o_is_jump    = 1'b0;
    o_jump_taken = 1'b0;
    o_is_halt    = 1'b0;
    case (i_opcode)
      OP_OUT:  o_is_out = 1'b1;
      OP_JMP: begin
        o_is_jump    = 1'b1;
        o_jump_taken = 1'b1;
      end
      OP_JC: begin
        o_is_jump    = 1'b1;
        o_jump_taken = i_c_flag;
      end
      OP_JZ: begin
        o_is_jump    = 1'b1;
        o_jump_taken = i_z_flag;
      end
      OP_JNC: begin
        o_is_jump    = 1'b1;
        o_jump_taken = ~i_c_flag;
      end
      OP_JNZ: begin
        o_is_jump    = 1'b1;
        o_jump_taken = ~i_z_flag;
      end
      OP_HALT: o_is_halt = 1'b1;
      // NOP, ALU ops and the reserved opcode need no extra flags.
      default: o_is_halt = 1'b0;
    endcase
  end

endmodule

// File: rtl/nibble_fetch_decode.sv
// nibble_fetch_decode: multi-cycle fetch/decode sequencer for the 4-bit
// accumulator datapath. Fetches {opcode, operand} words from a synchronous
// ROM (data one cycle after address) and drives the datapath controls.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset
//   run    : start request, only looked at in IDLE
//   step   : single-step strobe (only with SINGLE_STEP_EN defined)
//   bus    : nibble_fetch_decode_if.master -- rom_addr/rom_data, c_in/z_in,
//            data_in, control, load_acu, enable_out_alu, halted
//
// Optional feature macro: SINGLE_STEP_EN. When defined, every entry into
// FETCH (after IDLE start and after each instruction) waits for step==1.
//
// Instruction timing: FETCH, DECODE, EXECUTE (+ FLAGS for ALU ops).
module nibble_fetch_decode
  import nibble_pkg::*;
#(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  nibble_fetch_decode_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e             r_state;
  state_e             w_state_nxt;
  state_e             w_resume;
  logic               w_fetch_go;

  logic [ADDR_W-1:0]  r_pc,      w_pc_nxt;
  logic [INSTR_W-1:0] r_ir,      w_ir_nxt;
  logic [OPND_W-1:0]  r_data_in, w_data_in_nxt;
  logic [CTRL_W-1:0]  r_control, w_control_nxt;
  logic               r_load,    w_load_nxt;
  logic               r_en_out,  w_en_out_nxt;
  logic               r_halted,  w_halted_nxt;
  logic               r_c_flag,  w_c_flag_nxt;
  logic               r_z_flag,  w_z_flag_nxt;

  logic w_is_alu, w_is_out, w_is_jump, w_jump_taken, w_is_halt;
  logic [ADDR_W-1:0] w_jump_target;

`ifdef SINGLE_STEP_EN
  assign w_fetch_go = step;
`else
  assign w_fetch_go = 1'b1;
`endif

  // Where an instruction boundary goes next: straight to FETCH or the step stall.
  assign w_resume = w_fetch_go ? ST_FETCH : ST_STEP;

  // Operand zero-extended to the PC width.
  assign w_jump_target = ADDR_W'(r_ir[OPND_W-1:0]);

  nibble_decoder u_decoder (
    .i_opcode     (r_ir[INSTR_W-1:OPND_W]),
    .i_c_flag     (r_c_flag),
    .i_z_flag     (r_z_flag),
    .o_is_alu     (w_is_alu),
    .o_is_out     (w_is_out),
    .o_is_jump    (w_is_jump),
    .o_jump_taken (w_jump_taken),
    .o_is_halt    (w_is_halt)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt = w_resume;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STEP:    w_state_nxt = w_resume;
      ST_FETCH:   w_state_nxt = ST_DECODE;
      ST_DECODE:  w_state_nxt = ST_EXECUTE;
      ST_EXECUTE: begin
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_is_alu) begin
          w_state_nxt = ST_FLAGS;
        end else begin
          w_state_nxt = w_resume;
        end
      end
      ST_FLAGS:   w_state_nxt = w_resume;
      ST_HALT:    w_state_nxt = ST_HALT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of PC, IR, flags and datapath controls for each state.
  always_comb begin
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_data_in_nxt = r_data_in;
    w_control_nxt = r_control;
    w_load_nxt    = 1'b0;
    w_en_out_nxt  = r_en_out;
    w_halted_nxt  = r_halted;
    w_c_flag_nxt  = r_c_flag;
    w_z_flag_nxt  = r_z_flag;
    case (r_state)
      ST_DECODE: begin
        w_ir_nxt      = bus.rom_data;
        w_data_in_nxt = bus.rom_data[OPND_W-1:0];
        w_pc_nxt      = r_pc + PC_ONE;
        // load_acu is registered here so it is high for exactly the EXECUTE cycle.
        if (f_is_alu(bus.rom_data[INSTR_W-1:OPND_W])) begin
          w_control_nxt = bus.rom_data[OPND_W+CTRL_W-1:OPND_W];
          w_load_nxt    = 1'b1;
        end else begin
          w_control_nxt = r_control;
          w_load_nxt    = 1'b0;
        end
      end
      ST_EXECUTE: begin
        if (w_is_out) begin
          w_en_out_nxt = r_ir[0];
        end else begin
          w_en_out_nxt = r_en_out;
        end
        // Overrides the increment made in DECODE.
        if (w_is_jump && w_jump_taken) begin
          w_pc_nxt = w_jump_target;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (w_is_halt) begin
          w_halted_nxt = 1'b1;
        end else begin
          w_halted_nxt = r_halted;
        end
      end
      ST_FLAGS: begin
        // The accumulator settled at the EXECUTE edge, so c_in/z_in are current.
        w_c_flag_nxt = bus.c_in;
        w_z_flag_nxt = bus.z_in;
      end
      default: begin
        w_load_nxt = 1'b0;
      end
    endcase
  end

  // PC, IR, flag and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= PC_RESET;
      r_ir      <= {INSTR_W{1'b0}};
      r_data_in <= {OPND_W{1'b0}};
      r_control <= {CTRL_W{1'b0}};
      r_load    <= 1'b0;
      r_en_out  <= 1'b0;
      r_halted  <= 1'b0;
      r_c_flag  <= 1'b0;
      r_z_flag  <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_data_in <= w_data_in_nxt;
      r_control <= w_control_nxt;
      r_load    <= w_load_nxt;
      r_en_out  <= w_en_out_nxt;
      r_halted  <= w_halted_nxt;
      r_c_flag  <= w_c_flag_nxt;
      r_z_flag  <= w_z_flag_nxt;
    end
  end

  assign bus.rom_addr       = r_pc;
  assign bus.data_in        = r_data_in;
  assign bus.control        = r_control;
  assign bus.load_acu       = r_load;
  assign bus.enable_out_alu = r_en_out;
  assign bus.halted         = r_halted;

endmodule

// File: tb/tb_nibble_fetch_decode.sv
// Directed bench for nibble_fetch_decode: synchronous ROM model, a table of
// conditional-jump vectors, and hand-written multi-cycle sequences.
module tb_nibble_fetch_decode;

  logic clk;
  logic reset;
  logic run;
`ifdef SINGLE_STEP_EN
  logic step;
`endif

  int total;
  int bad;

  logic [7:0] rom [0:15];

  nibble_fetch_decode_if #(.ADDR_W(4)) bus ();

  nibble_fetch_decode #(.ADDR_W(4), .PC_RESET(4'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
`ifdef SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data valid one cycle after the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct {
    logic [7:0] op1;
    logic       c;
    logic       z;
    logic       flip;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Pulse run for one edge; returns in the first FETCH cycle.
  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    run   = 1'b0;
    bus.c_in = 1'b0;
    bus.z_in = 1'b0;
    bus.rom_data = 8'h00;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    clear_rom();

    //           op1    c     z     flip  exp
    vecs[0]  = '{8'hB5, 1'b0, 1'b1, 1'b0, 4'h5};  // JZ taken
    vecs[1]  = '{8'hB5, 1'b0, 1'b0, 1'b0, 4'h2};  // JZ not taken
    vecs[2]  = '{8'hD5, 1'b0, 1'b1, 1'b0, 4'h2};  // JNZ not taken
    vecs[3]  = '{8'hD5, 1'b0, 1'b0, 1'b0, 4'h5};  // JNZ taken
    vecs[4]  = '{8'hA7, 1'b1, 1'b0, 1'b0, 4'h7};  // JC taken
    vecs[5]  = '{8'hA7, 1'b0, 1'b0, 1'b0, 4'h2};  // JC not taken
    vecs[6]  = '{8'hC7, 1'b1, 1'b0, 1'b0, 4'h2};  // JNC not taken
    vecs[7]  = '{8'hC7, 1'b0, 1'b0, 1'b0, 4'h7};  // JNC taken
    vecs[8]  = '{8'hB5, 1'b0, 1'b1, 1'b1, 4'h5};  // live z drops after FLAGS: still taken
    vecs[9]  = '{8'hA7, 1'b0, 1'b0, 1'b1, 4'h2};  // live c rises after FLAGS: not taken
    vecs[10] = '{8'h91, 1'b0, 1'b0, 1'b0, 4'h1};  // JMP to itself
    vecs[11] = '{8'hE3, 1'b0, 1'b0, 1'b0, 4'h2};  // reserved acts as NOP
    vecs[12] = '{8'h9C, 1'b0, 1'b0, 1'b0, 4'hC};  // JMP

    // ---- reset and idle ----
    tick();
    tick();
    chk("reset_outputs",
        {bus.rom_addr, bus.data_in, bus.control, bus.load_acu, bus.enable_out_alu, bus.halted},
        32'h0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_hold",
          {bus.rom_addr, bus.data_in, bus.control, bus.load_acu, bus.enable_out_alu, bus.halted},
          32'h0);
    end

    // ---- ALU op 0x3F, then JC 8 using the latched carry ----
    rom[0] = 8'h3F;
    rom[1] = 8'hA8;
    bus.c_in = 1'b1;
    bus.z_in = 1'b0;
    start();                                   // FETCH
    chk("alu_fetch_load", bus.load_acu, 1'b0);
    tick();                                    // DECODE
    chk("alu_decode_load", bus.load_acu, 1'b0);
    tick();                                    // EXECUTE
    chk("alu_exec_load", bus.load_acu, 1'b1);
    chk("alu_exec_data", bus.data_in, 4'hF);
    chk("alu_exec_ctrl", bus.control, 3'd3);
    tick();                                    // FLAGS
    chk("alu_flags_load", bus.load_acu, 1'b0);
    chk("alu_flags_data", bus.data_in, 4'hF);
    chk("alu_flags_ctrl", bus.control, 3'd3);
    tick();                                    // next FETCH
    chk("alu_next_addr", bus.rom_addr, 4'h1);
    bus.c_in = 1'b0;
    tick();
    tick();                                    // JC EXECUTE
    chk("jc_exec_data", bus.data_in, 4'h8);
    chk("jc_exec_ctrl_held", bus.control, 3'd3);
    tick();
    chk("jc_latched_carry", bus.rom_addr, 4'h8);

    // ---- OUT / HALT ----
    do_reset();
    clear_rom();
    rom[0] = 8'h81;
    rom[1] = 8'h80;
    rom[2] = 8'hF0;
    start();
    tick(); tick(); tick();
    chk("out_enable_1", bus.enable_out_alu, 1'b1);
    tick(); tick(); tick();
    chk("out_enable_0", bus.enable_out_alu, 1'b0);
    chk("not_yet_halted", bus.halted, 1'b0);
    tick(); tick(); tick();
    chk("halted_set", bus.halted, 1'b1);
    chk("halt_addr", bus.rom_addr, 4'h3);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick();
      chk("halt_sticky",
          {bus.halted, bus.rom_addr, bus.load_acu, bus.enable_out_alu},
          {1'b1, 4'h3, 1'b0, 1'b0});
    end
    run = 1'b0;

    // ---- conditional jump table ----
    for (int v = 0; v < 13; v++) begin
      do_reset();
      clear_rom();
      rom[0] = 8'h10;
      rom[1] = vecs[v].op1;
      bus.c_in = vecs[v].c;
      bus.z_in = vecs[v].z;
      start();                                 // FETCH ALU
      tick();
      tick();                                  // EXECUTE ALU
      chk("tbl_alu_load", {bus.load_acu, bus.control}, {1'b1, 3'd1});
      tick();                                  // FLAGS
      tick();                                  // FETCH jump
      if (vecs[v].flip) begin
        bus.c_in = ~vecs[v].c;
        bus.z_in = ~vecs[v].z;
      end else begin
        bus.c_in = vecs[v].c;
        bus.z_in = vecs[v].z;
      end
      tick();
      tick();                                  // EXECUTE jump
      chk("tbl_jump_operand", bus.data_in, vecs[v].op1[3:0]);
      tick();                                  // next FETCH
      chk($sformatf("tbl_next_addr[%0d]", v), bus.rom_addr, vecs[v].exp);
    end
    bus.c_in = 1'b0;
    bus.z_in = 1'b0;

    // ---- PC wrap via JMP 0xF / NOP ----
    do_reset();
    clear_rom();
    rom[0] = 8'h9F;
    start();
    tick(); tick(); tick();
    chk("wrap_jump_addr", bus.rom_addr, 4'hF);
    tick(); tick(); tick();
    chk("wrap_addr", bus.rom_addr, 4'h0);

    // ---- reset during ALU EXECUTE ----
    do_reset();
    clear_rom();
    rom[0] = 8'h25;
    start();
    tick();
    tick();                                    // EXECUTE
    chk("midreset_load_before", bus.load_acu, 1'b1);
    reset = 1'b0;
    tick();
    chk("midreset_after",
        {bus.rom_addr, bus.load_acu, bus.data_in, bus.control},
        32'h0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midreset_idle", {bus.rom_addr, bus.load_acu}, 32'h0);
    end

`ifdef SINGLE_STEP_EN
    // ---- single step over NOPs ----
    do_reset();
    clear_rom();
    step = 1'b0;
    start();
    for (int i = 0; i < 7; i++) tick();
    chk("step_stalled", bus.rom_addr, 4'h0);
    for (int k = 1; k < 5; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("step_advance", bus.rom_addr, k[3:0]);
    end
    step = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
